// File: rtl/uart_pkg.sv
// Shared UART receive-path definitions.
// Provides the data width, the layout of a stored receive entry
// (bit 8 = framing-error tag, bits 7:0 = data) and the error-counter ceiling.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS  = 8;
  localparam int unsigned UART_RX_ENTRY_W = 9;
  localparam int unsigned ERRCNT_MAX      = 255;

  // Field order places err at bit 8 and data at bits 7:0.
  typedef struct packed {
    logic                      err;
    logic [UART_DATA_BITS-1:0] data;
  } uart_rx_entry_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Storage array for the receive FIFO.
// Ports:
//   clk    - write clock
//   we     - write enable
//   waddr  - write pointer
//   wdata  - entry to store
//   raddr  - read pointer
//   rdata  - entry at raddr, combinational
// The array is deliberately not reset; validity is tracked by the owner.
module uart_fifo_mem #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 9
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT buffer behind the UART receiver.
// Captures {rxErr, rxByte} on each rising edge of rxDone and presents entries
// over a valid/ready handshake.
// Ports:
//   clk, rstN              - clock, async active-low reset
//   rxDone, rxErr, rxByte  - frame from the receiver
//   outValid, outReady     - consumer handshake
//   outData, outErr        - head entry (zero while outValid is low)
//   level, full, empty     - occupancy status
//   overflow, overflowClr  - sticky lost-frame flag and its clear
//   errCount               - saturating framing-error count
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH    = 16,
  parameter bit          DROP_ERR = 1'b0
) (
  input  logic                      clk,
  input  logic                      rstN,
  input  logic                      rxDone,
  input  logic                      rxErr,
  input  logic [UART_DATA_BITS-1:0] rxByte,
  output logic                      outValid,
  input  logic                      outReady,
  output logic [UART_DATA_BITS-1:0] outData,
  output logic                      outErr,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      full,
  output logic                      empty,
  output logic                      overflow,
  input  logic                      overflowClr,
  output logic [7:0]                errCount
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  logic            done_prev_q;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0] level_q, level_d;
  logic            overflow_q, overflow_d;
  logic [7:0]      err_cnt_q, err_cnt_d;

  logic           push_req, store, pop, wr_en, ovf_event;
  uart_rx_entry_t wr_entry, rd_entry;

  assign push_req  = rxDone & ~done_prev_q;
  assign store     = push_req & ~(DROP_ERR & rxErr);
  assign pop       = outValid & outReady;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign wr_en     = store & (~full | pop);
  assign ovf_event = store & full & ~pop;
  assign wr_entry  = {rxErr, rxByte};

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (UART_RX_ENTRY_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr_q),
    .wdata (wr_entry),
    .raddr (rd_ptr_q),
    .rdata (rd_entry)
  );

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    err_cnt_d  = err_cnt_q;

    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;

    case ({wr_en, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    // Set has priority over clear.
    if (ovf_event)        overflow_d = 1'b1;
    else if (overflowClr) overflow_d = 1'b0;

    if (push_req && rxErr && (err_cnt_q != 8'(ERRCNT_MAX))) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      // High so a rxDone already asserted at reset release is not a new frame.
      done_prev_q <= 1'b1;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      done_prev_q <= rxDone;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign level    = level_q;
  assign full     = (level_q == LvlW'(DEPTH));
  assign empty    = (level_q == '0);
  assign outValid = ~empty;
  // Masked so the unreset array never leaks onto the outputs.
  assign outData  = outValid ? rd_entry.data : '0;
  assign outErr   = outValid & rd_entry.err;
  assign overflow = overflow_q;
  assign errCount = err_cnt_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

  localparam int unsigned D = 4;

  logic       clk = 1'b0;
  logic       rstN;
  logic       rxDone, rxErr, outReady, overflowClr;
  logic [7:0] rxByte;

  logic       out_valid, out_err, full_o, empty_o, ovf_o;
  logic [7:0] out_data, err_cnt;
  logic [2:0] level_o;

  logic       out_valid_d, out_err_d, full_d, empty_d, ovf_d;
  logic [7:0] out_data_d, err_cnt_d;
  logic [2:0] level_d;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(.DEPTH(D), .DROP_ERR(1'b0)) dut (
    .clk(clk), .rstN(rstN), .rxDone(rxDone), .rxErr(rxErr), .rxByte(rxByte),
    .outValid(out_valid), .outReady(outReady), .outData(out_data), .outErr(out_err),
    .level(level_o), .full(full_o), .empty(empty_o), .overflow(ovf_o),
    .overflowClr(overflowClr), .errCount(err_cnt)
  );

  uart_rx_fifo #(.DEPTH(D), .DROP_ERR(1'b1)) dut_drop (
    .clk(clk), .rstN(rstN), .rxDone(rxDone), .rxErr(rxErr), .rxByte(rxByte),
    .outValid(out_valid_d), .outReady(outReady), .outData(out_data_d), .outErr(out_err_d),
    .level(level_d), .full(full_d), .empty(empty_d), .overflow(ovf_d),
    .overflowClr(overflowClr), .errCount(err_cnt_d)
  );

  typedef struct {
    logic       done;
    logic [7:0] rx_b;
    logic       ready;
    int         cycles;
    logic       exp_valid;
    logic [7:0] exp_data;
    int         exp_level;
    logic       exp_empty;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b, input logic e);
    rxByte = b;
    rxErr  = e;
    rxDone = 1'b1;
    tick();
    rxDone = 1'b0;
    rxErr  = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    rxDone = 1'b0;
    rstN   = 1'b0;
    #2;
    rstN   = 1'b1;
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " valid"},     32'(out_valid), 0);
    check({tag, " data"},      32'(out_data),  0);
    check({tag, " err"},       32'(out_err),   0);
    check({tag, " level"},     32'(level_o),   0);
    check({tag, " full"},      32'(full_o),    0);
    check({tag, " empty"},     32'(empty_o),   1);
    check({tag, " overflow"},  32'(ovf_o),     0);
    check({tag, " errcount"},  32'(err_cnt),   0);
    check({tag, " drop level"},    32'(level_d),   0);
    check({tag, " drop errcount"}, 32'(err_cnt_d), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] drain_exp[4];

    vecs[0] = '{1'b1, 8'h55, 1'b0, 5, 1'b1, 8'h55, 1, 1'b0};
    vecs[1] = '{1'b0, 8'h00, 1'b0, 1, 1'b1, 8'h55, 1, 1'b0};
    vecs[2] = '{1'b1, 8'hA3, 1'b0, 5, 1'b1, 8'h55, 2, 1'b0};
    vecs[3] = '{1'b0, 8'h00, 1'b0, 1, 1'b1, 8'h55, 2, 1'b0};
    vecs[4] = '{1'b1, 8'h0F, 1'b0, 5, 1'b1, 8'h55, 3, 1'b0};
    vecs[5] = '{1'b0, 8'h00, 1'b0, 1, 1'b1, 8'h55, 3, 1'b0};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 1, 1'b1, 8'hA3, 2, 1'b0};
    vecs[7] = '{1'b0, 8'h00, 1'b1, 1, 1'b1, 8'h0F, 1, 1'b0};
    vecs[8] = '{1'b0, 8'h00, 1'b1, 1, 1'b0, 8'h00, 0, 1'b1};

    // Reset with rxDone held high: no push at release.
    rstN = 1'b0; rxDone = 1'b1; rxErr = 1'b0; rxByte = 8'h99;
    outReady = 1'b0; overflowClr = 1'b0;
    #1;
    check_reset_outputs("async reset");
    repeat (2) tick();
    rstN = 1'b1;
    repeat (3) tick();
    check_reset_outputs("release high done");
    rxDone = 1'b0;
    tick();

    // Three frames, stored then drained in order.
    foreach (vecs[i]) begin
      rxDone   = vecs[i].done;
      rxByte   = vecs[i].rx_b;
      outReady = vecs[i].ready;
      repeat (vecs[i].cycles) tick();
      check($sformatf("vec%0d valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid)
        check($sformatf("vec%0d data", i), 32'(out_data), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d level", i), 32'(level_o), vecs[i].exp_level);
      check($sformatf("vec%0d empty", i), 32'(empty_o), 32'(vecs[i].exp_empty));
    end
    outReady = 1'b0;

    // Overflow: fifth frame lost; clear in same cycle loses to set.
    do_reset();
    for (int i = 1; i <= 4; i++) push(8'(i), 1'b0);
    check("four frames full", 32'(full_o), 1);
    rxByte = 8'h05; rxDone = 1'b1; overflowClr = 1'b1;
    tick();
    rxDone = 1'b0; overflowClr = 1'b0;
    tick();
    check("ovf full", 32'(full_o), 1);
    check("ovf set wins", 32'(ovf_o), 1);
    check("ovf level", 32'(level_o), 4);
    outReady = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("ovf read%0d valid", i), 32'(out_valid), 1);
      check($sformatf("ovf read%0d data", i), 32'(out_data), i);
      tick();
    end
    check("ovf drained empty", 32'(empty_o), 1);
    check("ovf drained valid", 32'(out_valid), 0);
    check("ovf sticky", 32'(ovf_o), 1);
    outReady = 1'b0;
    overflowClr = 1'b1;
    tick();
    overflowClr = 1'b0;
    check("ovf cleared", 32'(ovf_o), 0);

    // Full with simultaneous pop and push.
    do_reset();
    for (int i = 0; i < 4; i++) push(8'h10 + 8'(i), 1'b0);
    rxByte = 8'h77; rxDone = 1'b1; outReady = 1'b1;
    tick();
    rxDone = 1'b0;
    check("fullpop level", 32'(level_o), 4);
    check("fullpop overflow", 32'(ovf_o), 0);
    drain_exp[0] = 8'h11; drain_exp[1] = 8'h12; drain_exp[2] = 8'h13; drain_exp[3] = 8'h77;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("fullpop head%0d", k), 32'(out_data), 32'(drain_exp[k]));
      tick();
    end
    check("fullpop empty", 32'(empty_o), 1);
    outReady = 1'b0;

    // Error-tagged frame, stored vs dropped.
    do_reset();
    rxByte = 8'h3C; rxErr = 1'b1; rxDone = 1'b1;
    tick();
    rxDone = 1'b0; rxErr = 1'b0;
    check("err head valid", 32'(out_valid), 1);
    check("err head data", 32'(out_data), 32'h3C);
    check("err head tag", 32'(out_err), 1);
    check("err count", 32'(err_cnt), 1);
    check("drop level", 32'(level_d), 0);
    check("drop empty", 32'(empty_d), 1);
    check("drop errcount", 32'(err_cnt_d), 1);
    tick();

    // Saturation under continuous drain, then async reset mid-stream.
    outReady = 1'b1;
    for (int i = 0; i < 300; i++) push(8'(i), 1'b1);
    check("errcount saturated", 32'(err_cnt), 255);
    check("drop errcount saturated", 32'(err_cnt_d), 255);
    check("drain keeps up", 32'(ovf_o), 0);
    rxByte = 8'hAA; rxErr = 1'b1; rxDone = 1'b1;
    tick();
    check("midstream valid", 32'(out_valid), 1);
    #2;
    rstN = 1'b0;
    #1;
    check_reset_outputs("midstream reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer sitting directly downstream of the Uart8 receiver. It captures every completed frame (`rxOut`, `rxErr`) on the rising edge of `rxDone`. Each frame is stored as a 9-bit entry (byte plus framing-error tag) in a first-word-fall-through FIFO. The consumer drains entries over a valid/ready handshake. The block also keeps a sticky overflow flag and a saturating framing-error counter.

## Interface
Parameters:
- `DEPTH`, 16, number of entries; power of two, ≥ 2.
- `DROP_ERR`, 0, when 1, frames with `rxErr` = 1 are counted but not stored.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `rstN`  in  1  asynchronous, active-low reset.
- `rxDone`  in  1  receiver frame-complete; level or pulse of any width ≥ 1 cycle.
- `rxErr`  in  1  receiver framing error for the frame flagged by `rxDone`.
- `rxByte`  in  8  received byte, valid while `rxDone` is high.
- `outValid`  out  1  head entry available.
- `outReady`  in  1  consumer accepts head entry.
- `outData`  out  8  head byte.
- `outErr`  out  1  head entry's framing-error tag.
- `level`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `full`  out  1  level == DEPTH.
- `empty`  out  1  level == 0.
- `overflow`  out  1  sticky: a frame was lost because the FIFO was full.
- `overflowClr`  in  1  clears `overflow`.
- `errCount`  out  8  framing errors seen, saturates at 255.

## Operation
- Edge detect: register `donePrev`. Push request = `rxDone & ~donePrev`. `donePrev` resets to 1, so a `rxDone` already high at reset release produces no push.
- On push request, capture {`rxErr`, `rxByte`} in the same cycle.
- If `rxErr` = 1, `errCount` increments (saturating), regardless of `DROP_ERR` or fullness.
- Store rule: the entry is written unless `DROP_ERR` = 1 and `rxErr` = 1.
- Pop: occurs when `outValid & outReady`.
- Full handling:
  - Write while full with a pop in the same cycle: both happen, and `level` stays DEPTH.
  - Write while full without a pop: the entry is discarded, `overflow` sets, and `level` is unchanged.
- `overflow` clears on `overflowClr`. If a new overflow event and `overflowClr` occur in the same cycle, set wins.
- Pointers: `$clog2(DEPTH)`-bit read/write pointers wrap naturally modulo DEPTH. `level` is a separate counter: +1 on write only, −1 on pop only, unchanged on both or neither.
- `outData`/`outErr` show the head entry whenever `outValid` = 1; they are don't-care when `outValid` = 0.

## Timing
- Reset values: `outValid` 0, `outData` 0, `outErr` 0, `level` 0, `full` 0, `empty` 1, `overflow` 0, `errCount` 0, pointers 0.
- Push latency: a write in cycle N makes the entry visible at the head in cycle N+1. There is no same-cycle bypass; an empty FIFO with `outReady` = 1 still pops in cycle N+1.
- `level`, `full`, `empty` update in the cycle after the write/pop that caused the change.
- `outValid` deasserts the cycle after the last entry is popped. Back-to-back pops drain one entry per cycle.
- A reset assertion mid-operation clears contents, flags and counter immediately (asynchronous). No partial entry survives.

## Structure
- Shared package `uart_pkg`:
  - `UART_DATA_BITS` = 8.
  - `UART_RX_ENTRY_W` = 9, with entry field positions: bit 8 = err tag, bits 7:0 = data.
  - `ERRCNT_MAX` = 255.
- One sub-module, `uart_fifo_mem`:
  - Parameterised DEPTH × width storage array.
  - Registered write port, combinational read by pointer.
  - No reset on the array.
- The top level holds the edge detector, pointers, level counter, flags and error counter.

## Test plan
- Reset with `rxDone` held high, then release: no push; `level` = 0, `empty` = 1.
- Three frames 0x55, 0xA3, 0x0F, each with `rxDone` high for 5 cycles and `outReady` = 0: `level` = 3. Then `outReady` = 1: data pops in order 0x55, 0xA3, 0x0F on consecutive cycles, and `empty` = 1 afterwards.
- `DEPTH` = 4, five frames 0x01..0x05 with no reads: `full` = 1 and `overflow` = 1; reads return 0x01..0x04 only. Pulse `overflowClr`: `overflow` = 0.
- FIFO full, `outReady` = 1 continuously, new push 0x77 arrives: no overflow, `level` stays 4, and 0x77 emerges last.
- Frame 0x3C with `rxErr` = 1:
  - `DROP_ERR` = 0: entry read back with `outErr` = 1, and `errCount` = 1.
  - `DROP_ERR` = 1: nothing stored, and `errCount` = 1.
- 300 error frames with a continuous drain: `errCount` saturates at 255. Then assert `rstN` = 0 mid-stream: all outputs return to reset values within the same cycle.
